// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Revision 1.0 - initial release.
`default_nettype none

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [31:0] temp_hi;
    logic [31:0] temp_lo;
    logic        suppress;

    logic        accept;
    logic        move_hi;
    logic        move_lo;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_suppress;
    logic [3:0]  res_cnt;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_b;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_ovf;

    assign accept  = start && !req && !busy && (op >= OP_MULT) && (op <= OP_DIVU);
    assign move_hi = (op == OP_MTHI) && !req && !busy;
    assign move_lo = (op == OP_MTLO) && !req && !busy;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
    assign div_b   = (B == 32'd0) ? 32'd1 : B;
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign quot_s  = div_ovf ? 32'sh8000_0000 : ($signed(A) / $signed(div_b));
    assign rem_s   = div_ovf ? 32'sd0 : ($signed(A) % $signed(div_b));
    assign quot_u  = A / div_b;
    assign rem_u   = A % div_b;

    always_comb begin
        res_hi       = 32'd0;
        res_lo       = 32'd0;
        res_suppress = 1'b0;
        res_cnt      = MULT_LOAD;
        case (op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi       = rem_s;
                res_lo       = quot_s;
                res_suppress = (B == 32'd0);
                res_cnt      = DIV_LOAD;
            end
            OP_DIVU: begin
                res_hi       = rem_u;
                res_lo       = quot_u;
                res_suppress = (B == 32'd0);
                res_cnt      = DIV_LOAD;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_next = cnt;
        if (cnt != 4'd0) begin
            cnt_next = cnt - 4'd1;
        end else if (accept) begin
            cnt_next = res_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= 4'd0;
            busy     <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
            temp_hi  <= 32'd0;
            temp_lo  <= 32'd0;
            suppress <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            busy <= (cnt_next != 4'd0);
            if (accept) begin
                temp_hi  <= res_hi;
                temp_lo  <= res_lo;
                suppress <= res_suppress;
            end
            // Moves are gated by !busy, so they can never collide with a completion.
            if (cnt == 4'd1) begin
                if (!suppress) begin
                    HI <= temp_hi;
                    LO <= temp_lo;
                end
            end else begin
                if (move_hi) HI <= A;
                if (move_lo) LO <= A;
            end
        end
    end

    always_comb begin
        mdu_out = 32'd0;
        if (op == OP_MFHI) mdu_out = HI;
        else if (op == OP_MFLO) mdu_out = LO;
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit.
// Revision 1.0 - initial release.
`default_nettype none

module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_out;

    int checks;
    int errors;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one MDU op and counts the cycles busy is observed high (bounded).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        cycles = busy ? 1 : 0;
        for (int i = 0; i < 40 && busy; i++) begin
            tick();
            if (busy) cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", LO); end
    endtask

    task automatic test_mult();
        int n;
        run_op(4'd1, 32'hFFFF_FFFF, 32'd2, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_cycles got %0d want 5", n); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", LO); end
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_cycles got %0d want 5", n); end
        checks++; if (HI !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got %h want 00000001", HI); end
        checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", LO); end
    endtask

    task automatic test_div();
        int n;
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_cycles got %0d want 10", n); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", HI); end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", HI); end
        run_op(4'd4, 32'd100, 32'd7, n);
        checks++; if (LO !== 32'd14 || HI !== 32'd2) begin errors++; $display("FAIL divu got %h/%h want 2/e", HI, LO); end
    endtask

    task automatic test_div_zero();
        int n;
        op = 4'd7; A = 32'h11; tick();
        op = 4'd8; A = 32'h22; tick();
        op = 4'd0; A = 32'd0;
        checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL move_setup got %h/%h want 11/22", HI, LO); end
        run_op(4'd4, 32'd7, 32'd0, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divz_cycles got %0d want 10", n); end
        checks++; if (HI !== 32'h11) begin errors++; $display("FAIL divz_hi got %h want 11", HI); end
        checks++; if (LO !== 32'h22) begin errors++; $display("FAIL divz_lo got %h want 22", LO); end
    endtask

    task automatic test_flush();
        req = 1'b1; start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0; op = 4'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", busy); end
        op = 4'd7; A = 32'd5;
        tick();
        req = 1'b0; op = 4'd0; A = 32'd0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_late got %0b want 0", busy); end
        checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL flush_hilo got %h/%h want 11/22", HI, LO); end
    endtask

    task automatic test_move_read();
        op = 4'd8; A = 32'h1234;
        tick();
        op = 4'd0; A = 32'd0;
        checks++; if (LO !== 32'h1234) begin errors++; $display("FAIL mtlo got %h want 1234", LO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %0b want 0", busy); end
        op = 4'd6; #1;
        checks++; if (mdu_out !== 32'h1234) begin errors++; $display("FAIL mflo got %h want 1234", mdu_out); end
        op = 4'd5; #1;
        checks++; if (mdu_out !== 32'h11) begin errors++; $display("FAIL mfhi got %h want 11", mdu_out); end
        op = 4'd0; #1;
        checks++; if (mdu_out !== 32'd0) begin errors++; $display("FAIL mdu_out_none got %h want 0", mdu_out); end
    endtask

    task automatic test_back_to_back();
        int n;
        start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0; op = 4'd0;
        n = busy ? 1 : 0;
        tick(); if (busy) n++;
        start = 1'b1; op = 4'd2; A = 32'd9; B = 32'd9;
        tick(); if (busy) n++;
        start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        for (int i = 0; i < 40 && busy; i++) begin
            tick();
            if (busy) n++;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_cycles got %0d want 5", n); end
        checks++; if (HI !== 32'd0 || LO !== 32'd12) begin errors++; $display("FAIL b2b_result got %h/%h want 0/c", HI, LO); end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got %0b want 0", busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rstrun_hilo got %h/%h want 0/0", HI, LO); end
        for (int i = 0; i < 12; i++) tick();
        checks++; if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstrun_late got %h/%h busy %0b want 0/0 busy 0", HI, LO, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_flush();
        test_move_read();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
